// File: rtl/rob_multiport.sv
// Multi-port reorder buffer: in-order allocate/commit, out-of-order writeback
// and result reads, with full flush and exception tagging on the head entry.
module rob_multiport #(
  parameter int DEPTH   = 256,
  parameter int DATA_W  = 64,
  parameter int PC_W    = 64,
  parameter int ARF_W   = 5,
  parameter int FLAG_W  = 12,
  parameter int NUM_WB  = 2,
  parameter int NUM_RD  = 2,
  parameter int EXC_BIT = 11,
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic                       clock,
  input  logic                       _reset,
  output logic                       alloc_ready,
  output logic [IDX_W-1:0]           alloc_slot,
  input  logic                       alloc_valid,
  input  logic [ARF_W-1:0]           alloc_arf,
  input  logic [PC_W-1:0]            alloc_pc,
  input  logic [NUM_WB-1:0]          wb_valid,
  input  logic [NUM_WB*IDX_W-1:0]    wb_slot,
  input  logic [NUM_WB*DATA_W-1:0]   wb_result,
  input  logic [NUM_WB*FLAG_W-1:0]   wb_flags,
  input  logic [NUM_RD*IDX_W-1:0]    rd_slot,
  output logic [NUM_RD*DATA_W-1:0]   rd_result,
  output logic [NUM_RD-1:0]          rd_valid,
  output logic                       commit_valid,
  input  logic                       commit_ready,
  output logic [ARF_W-1:0]           commit_arf,
  output logic [DATA_W-1:0]          commit_result,
  output logic [PC_W-1:0]            commit_pc,
  output logic [FLAG_W-1:0]          commit_flags,
  output logic                       commit_exc,
  input  logic                       flush,
  output logic [IDX_W:0]             count
);

  logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [IDX_W:0]   count_q, count_d;
  logic [DEPTH-1:0] busy_q, busy_d, done_q, done_d;

  logic [ARF_W-1:0]  arf_q    [DEPTH];
  logic [PC_W-1:0]   pc_q     [DEPTH];
  logic [DATA_W-1:0] result_q [DEPTH];
  logic [FLAG_W-1:0] flags_q  [DEPTH];

  logic [NUM_WB-1:0][IDX_W-1:0]  wb_slot_a;
  logic [NUM_WB-1:0][DATA_W-1:0] wb_res_a;
  logic [NUM_WB-1:0][FLAG_W-1:0] wb_flags_a;
  logic [NUM_RD-1:0][IDX_W-1:0]  rd_slot_a;
  logic [NUM_RD-1:0][DATA_W-1:0] rd_result_q, rd_result_d;
  logic [NUM_RD-1:0]             rd_valid_q, rd_valid_d;

  logic              full, empty, alloc_fire, commit_fire;
  logic [NUM_WB-1:0] wb_fire;

  assign wb_slot_a  = wb_slot;
  assign wb_res_a   = wb_result;
  assign wb_flags_a = wb_flags;
  assign rd_slot_a  = rd_slot;

  // Full/empty come from count alone since head==tail is ambiguous.
  assign full        = (count_q == (IDX_W+1)'(DEPTH));
  assign empty       = (count_q == '0);
  assign alloc_ready = !full;
  assign alloc_slot  = tail_q;
  assign count       = count_q;

  assign commit_valid  = !empty && busy_q[head_q] && done_q[head_q] && !flush;
  assign commit_arf    = arf_q[head_q];
  assign commit_result = result_q[head_q];
  assign commit_pc     = pc_q[head_q];
  assign commit_flags  = flags_q[head_q];
  assign commit_exc    = commit_valid && flags_q[head_q][EXC_BIT];

  assign alloc_fire  = alloc_valid && alloc_ready && !flush;
  assign commit_fire = commit_valid && commit_ready;

  // A writeback racing the commit of its own slot is dropped.
  always_comb begin
    for (int i = 0; i < NUM_WB; i++)
      wb_fire[i] = wb_valid[i] && busy_q[wb_slot_a[i]] && !flush &&
                   !(commit_fire && (wb_slot_a[i] == head_q));
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    busy_d  = busy_q;
    done_d  = done_q;
    if (flush) begin
      tail_d  = head_q;
      count_d = '0;
      busy_d  = '0;
      done_d  = '0;
    end else begin
      for (int i = 0; i < NUM_WB; i++)
        if (wb_fire[i]) done_d[wb_slot_a[i]] = 1'b1;
      if (commit_fire) begin
        busy_d[head_q] = 1'b0;
        done_d[head_q] = 1'b0;
        head_d         = head_q + 1'b1;
      end
      if (alloc_fire) begin
        busy_d[tail_q] = 1'b1;
        done_d[tail_q] = 1'b0;
        tail_d         = tail_q + 1'b1;
      end
      case ({alloc_fire, commit_fire})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    for (int j = 0; j < NUM_RD; j++) begin
      rd_result_d[j] = result_q[rd_slot_a[j]];
      rd_valid_d[j]  = done_q[rd_slot_a[j]];
    end
  end

  assign rd_result = rd_result_q;
  assign rd_valid  = rd_valid_q;

  always_ff @(posedge clock or negedge _reset) begin
    if (!_reset) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      busy_q      <= '0;
      done_q      <= '0;
      rd_result_q <= '0;
      rd_valid_q  <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_result_q <= rd_result_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  // Payload storage is never reset; busy/done gate every use of it.
  // Later ports overwrite earlier ones on a shared slot.
  always_ff @(posedge clock) begin
    if (alloc_fire) begin
      arf_q[tail_q] <= alloc_arf;
      pc_q[tail_q]  <= alloc_pc;
    end
    for (int i = 0; i < NUM_WB; i++)
      if (wb_fire[i]) begin
        result_q[wb_slot_a[i]] <= wb_res_a[i];
        flags_q[wb_slot_a[i]]  <= wb_flags_a[i];
      end
  end

endmodule
